md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- Issue and hazard controller for the multiply/divide unit in the E stage of the pipelined CPU.
- Decodes the E-stage multiply/divide-class operation, pulses the unit's start and selects its operation code, and gates the HI/LO writes.
- Tracks unit occupancy with its own countdown and raises the pipeline stall for any multiply/divide-class instruction that would collide with an operation in flight.
- Honours the exception flush from CP0.

Parameters:
- MULT_CYC, 5, busy cycles after a MULT/MULTU issue.
- DIV_CYC, 10, busy cycles after a DIV/DIVU issue.
- CNT_W, 4, countdown width; must hold max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  E-stage instruction valid.
- req_op  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 treated as none.
- req_divisor  in  32  rt operand; used only with the optional feature.
- flush  in  1  exception/interrupt flush of the E stage.
- md_start  out  1  one-cycle start to the unit.
- md_ctrl  out  3  unit opcode: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 0 otherwise.
- md_we  out  2  1 = write HI, 2 = write LO, 0 = none.
- md_rd_sel  out  1  0 = HI, 1 = LO, for the MF read mux.
- stall  out  1  freeze the F/D/E stages.
- busy  out  1  an operation is in flight.
- done  out  1  registered one-cycle pulse when an operation retires.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, done=0. All outputs read 0 while in reset.
- Classes:
  - start_op = op 1..4
  - mt_op = op 5..6
  - mf_op = op 7..8
  - md_class = any of the three
- Combinational outputs:
  - stall = req_valid & md_class & busy & ~flush.
  - accept = req_valid & ~flush & ~busy.
  - md_start = accept & start_op.
  - md_ctrl = op when md_start, else 0.
  - md_we = (accept & op==5) ? 1 : (accept & op==6) ? 2 : 0.
  - md_rd_sel = (op==8). It is driven whenever op is 7 or 8; the consumer qualifies it with ~stall.
- State machine, states IDLE / MUL_RUN / DIV_RUN:
  - IDLE: on md_start with op 1-2, go to MUL_RUN and load cnt=MULT_CYC. With op 3-4, go to DIV_RUN and load cnt=DIV_CYC.
  - RUN states: cnt decrements each edge. At the edge where cnt==1: cnt becomes 0, state becomes IDLE, done is set to 1 for exactly one cycle.
- busy = (state != IDLE).
- Latency: issue in cycle c0 gives busy=1 in cycles c1..c0+N and busy=0 with done=1 in cycle c0+N+1. A new request is accepted in that same cycle (back-to-back).
- Flush:
  - A flush in the issue cycle suppresses md_start and md_we; no state change.
  - A flush while busy does not cancel the operation in flight (MIPS semantics: an issued mult/div completes). It only deasserts stall for that cycle.
- Non-md requests (op 0 or 9-15) never stall and never drive the unit.
- Reset mid-operation: the countdown is abandoned immediately and done is not pulsed. The unit is reset by the same reset.
- The count is sized by CNT_W; no wrap can occur because cnt loads only from IDLE.

Optional Feature:
- MD_DIV0_SKIP_EN:
  - Defined: DIV/DIVU with req_divisor==0 is accepted (no stall) but md_start stays 0 and the state stays IDLE, so HI/LO are left unchanged.
  - Undefined: a divide by zero issues normally and occupies DIV_CYC cycles; the HI/LO result is unspecified.

Decomposition:
- Shared package md_pkg: req_op encodings (MD_OP_*), md_ctrl encodings, md_we encodings, state encodings, and default cycle counts.
- One sub-module, md_busy_cnt: the loadable countdown with the done pulse, instantiated once.

Test Plan:
- Single issue: MULT accepted at c0 -> md_start=1 and md_ctrl=1 at c0; busy=1 c1..c5; done=1 at c6; MFHI at c3 stalls until c6, md_rd_sel=0.
- Divide then back-to-back: DIVU at c0, MULTU held c1..c11 -> stall=1 for c1..c10; MULTU accepted at c11 with md_ctrl=2.
- MT while busy: MTLO during DIV_RUN -> stall until the done cycle; then md_we=2 for one cycle.
- Flush at issue: DIV with flush=1 -> md_start=0, busy stays 0. Flush at c2 during MULT -> busy still ends at c5, done at c6.
- Reset mid-op: reset=0 asynchronously at c4 of a DIV -> busy=0 and done=0 immediately; the first request after release is accepted.
- Divisor zero: with MD_DIV0_SKIP_EN, DIV with divisor 0 -> no start, no stall, busy=0. Without it -> busy for 10 cycles.

Source files
------------

// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg -- shared definitions for the multiply/divide issue controller.
//
// Contents:
//   md_op_e     E-stage request operation encodings (MD_OP_*)
//   MD_CTRL_*   opcode encodings presented to the multiply/divide unit
//   MD_WE_*     HI/LO write-enable encodings
//   md_state_e  issue controller state encodings
//   MD_*_DEF    default cycle counts and countdown width
//   md_class_t  decoded operation class, produced by md_decode()
// -----------------------------------------------------------------------------
package md_pkg;

  typedef enum logic [3:0] {
    MD_OP_NONE  = 4'd0,
    MD_OP_MULT  = 4'd1,
    MD_OP_MULTU = 4'd2,
    MD_OP_DIV   = 4'd3,
    MD_OP_DIVU  = 4'd4,
    MD_OP_MTHI  = 4'd5,
    MD_OP_MTLO  = 4'd6,
    MD_OP_MFHI  = 4'd7,
    MD_OP_MFLO  = 4'd8
  } md_op_e;

  localparam logic [2:0] MD_CTRL_NONE  = 3'd0;
  localparam logic [2:0] MD_CTRL_MULT  = 3'd1;
  localparam logic [2:0] MD_CTRL_MULTU = 3'd2;
  localparam logic [2:0] MD_CTRL_DIV   = 3'd3;
  localparam logic [2:0] MD_CTRL_DIVU  = 3'd4;

  localparam logic [1:0] MD_WE_NONE = 2'd0;
  localparam logic [1:0] MD_WE_HI   = 2'd1;
  localparam logic [1:0] MD_WE_LO   = 2'd2;

  typedef enum logic [1:0] {
    MD_IDLE    = 2'd0,
    MD_MUL_RUN = 2'd1,
    MD_DIV_RUN = 2'd2
  } md_state_e;

  localparam int MD_MULT_CYC_DEF = 5;
  localparam int MD_DIV_CYC_DEF  = 10;
  localparam int MD_CNT_W_DEF    = 4;

  typedef struct packed {
    logic start_op;  // MULT/MULTU/DIV/DIVU: occupies the unit
    logic mt_op;     // MTHI/MTLO: writes HI or LO
    logic mf_op;     // MFHI/MFLO: reads HI or LO
    logic md_class;  // any of the above; must wait for the unit
  } md_class_t;

  // Encodings 9..15 fall through every test and decode as "none".
  function automatic md_class_t md_decode(input logic [3:0] op);
    md_class_t c;
    c.start_op = (op >= MD_OP_MULT) && (op <= MD_OP_DIVU);
    c.mt_op    = (op == MD_OP_MTHI) || (op == MD_OP_MTLO);
    c.mf_op    = (op == MD_OP_MFHI) || (op == MD_OP_MFLO);
    c.md_class = c.start_op | c.mt_op | c.mf_op;
    return c;
  endfunction

endpackage

// File: rtl/md_issue_ctrl_busy_cnt.sv
// -----------------------------------------------------------------------------
// md_busy_cnt -- loadable occupancy countdown for the multiply/divide unit.
//
// Loads load_val on load, then counts down to zero one step per clock. The
// edge that moves the count from 1 to 0 raises done for exactly one cycle.
// A reset abandons the count without pulsing done.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous reset, active low
//   load      in   load load_val into the count (only asserted while idle)
//   load_val  in   CNT_W  cycles the unit stays occupied
//   last      out  count is 1: the coming edge retires the operation
//   done      out  registered one-cycle retire pulse
// -----------------------------------------------------------------------------
module md_busy_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign last = (cnt == CNT_W'(1));

  // NOTE: async reset sits in the sensitivity list so the count is abandoned
  // the moment reset falls, not at the next clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; blocking here would chain cnt into done.
      done <= last;
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl -- issue and hazard controller for the E-stage
// multiply/divide unit.
//
// Decodes the E-stage request, pulses md_start with the unit opcode, gates
// the HI/LO writes and stalls F/D/E for any multiply/divide-class request
// that arrives while an operation is in flight. A flush suppresses a new
// issue but never cancels an operation already running.
//
// Build option:
//   MD_DIV0_SKIP_EN  when defined, DIV/DIVU with req_divisor == 0 is accepted
//                    without starting the unit (HI/LO left unchanged).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   req_valid    in   E-stage instruction valid
//   req_op       in   4   request operation (md_op_e; 9..15 = none)
//   req_divisor  in   32  rt operand, only looked at with MD_DIV0_SKIP_EN
//   flush        in   exception/interrupt flush of the E stage
//   md_start     out  one-cycle start to the unit
//   md_ctrl      out  3   unit opcode while md_start, else 0
//   md_we        out  2   1 = write HI, 2 = write LO, 0 = none
//   md_rd_sel    out  MF read mux select: 0 = HI, 1 = LO
//   stall        out  freeze F/D/E
//   busy         out  an operation is in flight
//   done         out  registered one-cycle retire pulse
// -----------------------------------------------------------------------------
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYC = MD_MULT_CYC_DEF,
  parameter int DIV_CYC  = MD_DIV_CYC_DEF,
  parameter int CNT_W    = MD_CNT_W_DEF   // must hold max(MULT_CYC, DIV_CYC)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_divisor,
  input  logic        flush,
  output logic        md_start,
  output logic [2:0]  md_ctrl,
  output logic [1:0]  md_we,
  output logic        md_rd_sel,
  output logic        stall,
  output logic        busy,
  output logic        done
);

  md_state_e        state;
  md_class_t        cls;
  logic             accept;
  logic             div_zero;
  logic             is_mul;
  logic             cnt_last;
  logic [CNT_W-1:0] load_val;

  assign cls    = md_decode(req_op);
  assign is_mul = (req_op == MD_OP_MULT) || (req_op == MD_OP_MULTU);

`ifdef MD_DIV0_SKIP_EN
  // A zero divisor is retired immediately: accepted, but the unit never runs.
  assign div_zero = ((req_op == MD_OP_DIV) || (req_op == MD_OP_DIVU)) &&
                    (req_divisor == 32'd0);
`else
  logic unused_divisor;
  assign div_zero       = 1'b0;
  assign unused_divisor = ^req_divisor;
`endif

  assign busy = (state != MD_IDLE);

  // The combinational outputs are qualified with reset so that every output
  // reads 0 while reset is held, whatever the request inputs are doing.
  assign stall     = reset & req_valid & cls.md_class & busy & ~flush;
  assign accept    = reset & req_valid & ~flush & ~busy;
  assign md_start  = accept & cls.start_op & ~div_zero;
  assign md_ctrl   = md_start ? req_op[2:0] : MD_CTRL_NONE;
  // Driven for any op; the consumer only uses it for MFHI/MFLO and ~stall.
  assign md_rd_sel = reset & (req_op == MD_OP_MFLO);

  // NOTE: always_comb assigns a default first so no path leaves md_we
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    md_we = MD_WE_NONE;
    if (accept && (req_op == MD_OP_MTHI)) begin
      md_we = MD_WE_HI;
    end else if (accept && (req_op == MD_OP_MTLO)) begin
      md_we = MD_WE_LO;
    end
  end

  assign load_val = is_mul ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);

  // The count only loads from IDLE, where it is already 0, so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            state <= is_mul ? MD_MUL_RUN : MD_DIV_RUN;
          end
        end
        MD_MUL_RUN, MD_DIV_RUN: begin
          if (cnt_last) begin
            state <= MD_IDLE;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  md_busy_cnt #(
    .CNT_W (CNT_W)
  ) u_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (md_start),
    .load_val (load_val),
    .last     (cnt_last),
    .done     (done)
  );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_issue_ctrl -- self-checking bench for md_issue_ctrl.
//
// Reference model: the unit is described by the cycle index of the last issue
// and its length N; busy holds for cycles issue+1 .. issue+N and done is seen
// in cycle issue+N+1. Combinational outputs follow the decode rules directly.
// -----------------------------------------------------------------------------
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_divisor;
  logic        flush;
  logic        md_start;
  logic [2:0]  md_ctrl;
  logic [1:0]  md_we;
  logic        md_rd_sel;
  logic        stall;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_divisor (req_divisor),
    .flush       (flush),
    .md_start    (md_start),
    .md_ctrl     (md_ctrl),
    .md_we       (md_we),
    .md_rd_sel   (md_rd_sel),
    .stall       (stall),
    .busy        (busy),
    .done        (done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc     = 0;
  int iss_cyc = -1000000;
  int iss_n   = 0;

  function automatic bit m_busy();
    return (cyc > iss_cyc) && (cyc <= iss_cyc + iss_n);
  endfunction

  function automatic bit m_done();
    return cyc == iss_cyc + iss_n + 1;
  endfunction

  // Outputs captured in the most recent cyc_step, for directed checks.
  logic       s_start, s_stall, s_busy, s_done, s_rd;
  logic [2:0] s_ctrl;
  logic [1:0] s_we;

  // Drive one cycle of request, compare every output with the model, then
  // advance across the clock edge and let the model record any issue.
  task automatic cyc_step(input logic v, input logic [3:0] op,
                          input logic [31:0] d, input logic f,
                          input string tag);
    bit         bz, cls, strt, acc, skip, e_start, e_stall, e_rd;
    logic [2:0] e_ctrl;
    logic [1:0] e_we;
    req_valid   = v;
    req_op      = op;
    req_divisor = d;
    flush       = f;
    #2;
    bz   = m_busy();
    cls  = (op >= 1) && (op <= 8);
    strt = (op >= 1) && (op <= 4);
    acc  = v && !f && !bz;
    skip = 1'b0;
`ifdef MD_DIV0_SKIP_EN
    skip = ((op == 3) || (op == 4)) && (d == 0);
`endif
    e_start = acc && strt && !skip;
    e_ctrl  = e_start ? op[2:0] : 3'd0;
    e_we    = (acc && op == 5) ? 2'd1 : (acc && op == 6) ? 2'd2 : 2'd0;
    e_rd    = (op == 8);
    e_stall = v && cls && bz && !f;
    s_start = md_start; s_ctrl = md_ctrl; s_we = md_we; s_rd = md_rd_sel;
    s_stall = stall;    s_busy = busy;    s_done = done;
    check({tag, "_start"}, md_start, e_start);
    check({tag, "_ctrl"},  md_ctrl,  e_ctrl);
    check({tag, "_we"},    md_we,    e_we);
    check({tag, "_rdsel"}, md_rd_sel, e_rd);
    check({tag, "_stall"}, stall,    e_stall);
    check({tag, "_busy"},  busy,     bz);
    check({tag, "_done"},  done,     m_done());
    @(posedge clk);
    #1;
    if (e_start) begin
      iss_cyc = cyc;
      iss_n   = (op <= 2) ? 5 : 10;
    end
    cyc++;
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc_step(1'b0, 4'd0, 32'd0, 1'b0, tag);
  endtask

  // ---------------- decode vectors (applied from idle) ----------------
  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [31:0] d;
    logic        f;
    logic        e_start;
    logic [2:0]  e_ctrl;
    logic [1:0]  e_we;
    logic        e_rd;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'd1,  32'd5, 1'b0, 1'b1, 3'd1, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'd2,  32'd5, 1'b0, 1'b1, 3'd2, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'd3,  32'd7, 1'b0, 1'b1, 3'd3, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 4'd4,  32'd7, 1'b0, 1'b1, 3'd4, 2'd0, 1'b0};
    vecs[4]  = '{1'b1, 4'd5,  32'd0, 1'b0, 1'b0, 3'd0, 2'd1, 1'b0};
    vecs[5]  = '{1'b1, 4'd6,  32'd0, 1'b0, 1'b0, 3'd0, 2'd2, 1'b0};
    vecs[6]  = '{1'b1, 4'd7,  32'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[7]  = '{1'b1, 4'd8,  32'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1};
    vecs[8]  = '{1'b1, 4'd9,  32'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, 4'd15, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 4'd1,  32'd5, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[11] = '{1'b1, 4'd5,  32'd0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[12] = '{1'b0, 4'd3,  32'd7, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vecs[13] = '{1'b0, 4'd8,  32'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1};

    // ---- reset: all outputs 0 even with a MULT request presented ----
    reset = 1'b0; req_valid = 1'b1; req_op = 4'd1; req_divisor = 32'd5;
    flush = 1'b0;
    #3;
    check("rst_start", md_start, 1'b0);
    check("rst_ctrl",  md_ctrl,  3'd0);
    check("rst_we",    md_we,    2'd0);
    check("rst_rdsel", md_rd_sel, 1'b0);
    check("rst_stall", stall,    1'b0);
    check("rst_busy",  busy,     1'b0);
    check("rst_done",  done,     1'b0);
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // ---- table: one vector per cycle, request withdrawn before the edge ----
    for (int i = 0; i < 14; i++) begin
      req_valid = vecs[i].v; req_op = vecs[i].op;
      req_divisor = vecs[i].d; flush = vecs[i].f;
      #2;
      check($sformatf("vec%0d_start", i), md_start, vecs[i].e_start);
      check($sformatf("vec%0d_ctrl", i),  md_ctrl,  vecs[i].e_ctrl);
      check($sformatf("vec%0d_we", i),    md_we,    vecs[i].e_we);
      check($sformatf("vec%0d_rdsel", i), md_rd_sel, vecs[i].e_rd);
      check($sformatf("vec%0d_stall", i), stall,    1'b0);
      req_valid = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("vec_busy_after", busy, 1'b0);

    // ---- single MULT, MFHI from c3 stalls until done at c6 ----
    cyc_step(1'b1, 4'd1, 32'd5, 1'b0, "t1_c0");
    check("t1_start", s_start, 1'b1);
    check("t1_ctrl",  s_ctrl,  3'd1);
    for (int k = 1; k <= 5; k++) begin
      if (k < 3) cyc_step(1'b0, 4'd0, 32'd0, 1'b0, "t1_run");
      else begin
        cyc_step(1'b1, 4'd7, 32'd0, 1'b0, "t1_mf");
        check("t1_mf_stall", s_stall, 1'b1);
        check("t1_mf_rdsel", s_rd,    1'b0);
      end
      check("t1_busy", s_busy, 1'b1);
    end
    cyc_step(1'b1, 4'd7, 32'd0, 1'b0, "t1_c6");
    check("t1_c6_stall", s_stall, 1'b0);
    check("t1_c6_done",  s_done,  1'b1);
    check("t1_c6_busy",  s_busy,  1'b0);

    // ---- DIVU then MULTU held: back-to-back accept in the done cycle ----
    cyc_step(1'b1, 4'd4, 32'd9, 1'b0, "t2_c0");
    check("t2_start", s_start, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      cyc_step(1'b1, 4'd2, 32'd0, 1'b0, "t2_hold");
      check("t2_hold_stall", s_stall, 1'b1);
      check("t2_hold_start", s_start, 1'b0);
    end
    cyc_step(1'b1, 4'd2, 32'd0, 1'b0, "t2_c11");
    check("t2_c11_stall", s_stall, 1'b0);
    check("t2_c11_start", s_start, 1'b1);
    check("t2_c11_ctrl",  s_ctrl,  3'd2);
    check("t2_c11_done",  s_done,  1'b1);
    idle_steps(7, "t2_drain");

    // ---- MTLO during DIV_RUN waits for the done cycle ----
    cyc_step(1'b1, 4'd3, 32'd3, 1'b0, "t3_c0");
    for (int k = 1; k <= 10; k++) begin
      cyc_step(1'b1, 4'd6, 32'd0, 1'b0, "t3_hold");
      check("t3_hold_stall", s_stall, 1'b1);
      check("t3_hold_we",    s_we,    2'd0);
    end
    cyc_step(1'b1, 4'd6, 32'd0, 1'b0, "t3_c11");
    check("t3_c11_we",    s_we,    2'd2);
    check("t3_c11_stall", s_stall, 1'b0);
    cyc_step(1'b0, 4'd0, 32'd0, 1'b0, "t3_c12");
    check("t3_c12_we", s_we, 2'd0);

    // ---- flush at issue, then flush while busy ----
    cyc_step(1'b1, 4'd3, 32'd7, 1'b1, "t4_fl_issue");
    check("t4_fl_start", s_start, 1'b0);
    cyc_step(1'b0, 4'd0, 32'd0, 1'b0, "t4_fl_after");
    check("t4_fl_busy", s_busy, 1'b0);
    cyc_step(1'b1, 4'd1, 32'd5, 1'b0, "t4_c0");
    cyc_step(1'b0, 4'd0, 32'd0, 1'b0, "t4_c1");
    cyc_step(1'b1, 4'd7, 32'd0, 1'b1, "t4_c2");
    check("t4_c2_stall", s_stall, 1'b0);
    check("t4_c2_busy",  s_busy,  1'b1);
    idle_steps(2, "t4_run");
    cyc_step(1'b0, 4'd0, 32'd0, 1'b0, "t4_c5");
    check("t4_c5_busy", s_busy, 1'b1);
    cyc_step(1'b0, 4'd0, 32'd0, 1'b0, "t4_c6");
    check("t4_c6_done", s_done, 1'b1);
    check("t4_c6_busy", s_busy, 1'b0);

    // ---- asynchronous reset at c4 of a DIV ----
    cyc_step(1'b1, 4'd3, 32'd7, 1'b0, "t5_c0");
    idle_steps(3, "t5_run");
    req_valid = 1'b1; req_op = 4'd1; req_divisor = 32'd5; flush = 1'b0;
    #2;
    check("t5_busy_pre", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("t5_busy_rst",  busy,     1'b0);
    check("t5_done_rst",  done,     1'b0);
    check("t5_start_rst", md_start, 1'b0);
    check("t5_stall_rst", stall,    1'b0);
    iss_cyc = -1000000;
    @(posedge clk); #1;
    cyc++;
    reset = 1'b1;
    cyc_step(1'b1, 4'd1, 32'd5, 1'b0, "t5_after");
    check("t5_after_start", s_start, 1'b1);
    idle_steps(6, "t5_drain");
    check("t5_no_stray_busy", busy, 1'b0);

    // ---- divide by zero ----
    cyc_step(1'b1, 4'd3, 32'd0, 1'b0, "t6_c0");
`ifdef MD_DIV0_SKIP_EN
    check("t6_start", s_start, 1'b0);
    check("t6_stall", s_stall, 1'b0);
    cyc_step(1'b0, 4'd0, 32'd0, 1'b0, "t6_c1");
    check("t6_busy", s_busy, 1'b0);
`else
    check("t6_start", s_start, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      cyc_step(1'b0, 4'd0, 32'd0, 1'b0, "t6_run");
      check("t6_busy", s_busy, 1'b1);
    end
    cyc_step(1'b0, 4'd0, 32'd0, 1'b0, "t6_c11");
    check("t6_c11_done", s_done, 1'b1);
    check("t6_c11_busy", s_busy, 1'b0);
`endif

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 1500; i++) begin
      logic        v, f;
      logic [3:0]  op;
      logic [31:0] d;
      v  = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      f  = ($urandom_range(0, 7) == 0);
      cyc_step(v, op, d, f, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
